date_set_ctrl: RTL and testbench

DATE_SET_CTRL -- requirements
Module: date_set_ctrl

---
 rtl/date_set_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_date_set_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/date_set_ctrl.sv
// date_set_ctrl: run/set controller for a calendar date counter.
// RUN forwards midnight rollovers as day_increment pulses. btn_mode walks
// through year, month and day edit fields, then COMMIT loads the edited
// date into the counter. Midnights seen while editing are held as pending
// and replayed on return to RUN. An idle timeout abandons the edit.
// Optional feature: define DATE_SET_LEAP_YEAR_EN to give February 29 days
// in years divisible by 4 (otherwise February always has 28 days).
module date_set_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500000000,
  parameter logic [31:0] BLINK_HALF     = 32'd25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midnight,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [6:0] cur_year,
  input  logic [3:0] cur_month,
  input  logic [4:0] cur_day,
  output logic       day_increment,
  output logic       load,
  output logic [6:0] load_year,
  output logic [3:0] load_month,
  output logic [4:0] load_day,
  output logic       set_active,
  output logic [1:0] field_sel,
  output logic       blink
);

  typedef enum logic [2:0] {RUN, SET_YEAR, SET_MONTH, SET_DAY, COMMIT} state_t;

  state_t      state_reg, state_next;
  logic [6:0]  year_reg;
  logic [3:0]  month_reg;
  logic [4:0]  day_reg;
  logic [31:0] idle_reg;
  logic [31:0] blink_cnt_reg;
  logic        pending_reg;
  logic        merge_reg;

  logic        in_set;
  logic        next_in_set;
  logic        idle_hit;
  logic        rejoin;
  logic        leap;
  logic [4:0]  dim;

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic is_leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:                    days_in_month = is_leap ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

`ifdef DATE_SET_LEAP_YEAR_EN
  assign leap = (year_reg[1:0] == 2'b00);
`else
  assign leap = 1'b0;
`endif

  assign dim         = days_in_month(month_reg, leap);
  assign in_set      = (state_reg == SET_YEAR) || (state_reg == SET_MONTH) || (state_reg == SET_DAY);
  assign next_in_set = (state_next == SET_YEAR) || (state_next == SET_MONTH) || (state_next == SET_DAY);
  assign idle_hit    = (idle_reg == TIMEOUT_CYCLES - 32'd1);
  // Leaving an edit (commit or timeout) back into RUN on this edge.
  assign rejoin      = (state_reg != RUN) && (state_next == RUN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  // Next-state: btn_mode wins over btn_inc; any press holds off the timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:       if (btn_mode) state_next = SET_YEAR;
      SET_YEAR:  if (btn_mode) state_next = SET_MONTH;
                 else if (!btn_inc && idle_hit) state_next = RUN;
      SET_MONTH: if (btn_mode) state_next = SET_DAY;
                 else if (!btn_inc && idle_hit) state_next = RUN;
      SET_DAY:   if (btn_mode) state_next = COMMIT;
                 else if (!btn_inc && idle_hit) state_next = RUN;
      COMMIT:    state_next = RUN;
      default:   state_next = RUN;
    endcase
  end

  // Edit registers: capture on entry, wrap-around increments, day clamp on month exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      year_reg  <= 7'd0;
      month_reg <= 4'd0;
      day_reg   <= 5'd0;
    end else begin
      case (state_reg)
        RUN: if (btn_mode) begin
          year_reg  <= cur_year;
          month_reg <= cur_month;
          day_reg   <= cur_day;
        end
        SET_YEAR: if (!btn_mode && btn_inc)
          year_reg <= (year_reg >= 7'd99) ? 7'd0 : year_reg + 7'd1;
        SET_MONTH: begin
          if (btn_mode) begin
            if (day_reg > dim) day_reg <= dim;
          end else if (btn_inc) begin
            month_reg <= (month_reg >= 4'd12) ? 4'd1 : month_reg + 4'd1;
          end
        end
        SET_DAY: if (!btn_mode && btn_inc)
          day_reg <= (day_reg >= dim) ? 5'd1 : day_reg + 5'd1;
        default: ;
      endcase
    end
  end

  // Idle counter: runs only in SET states, cleared by any press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              idle_reg <= 32'd0;
    else if (!in_set || btn_mode || btn_inc) idle_reg <= 32'd0;
    else                                  idle_reg <= idle_reg + 32'd1;
  end

  // Blink generator: restarts dark on every field change and every increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_reg <= 32'd0;
      blink         <= 1'b0;
    end else if (!next_in_set || (state_next != state_reg) || btn_inc) begin
      blink_cnt_reg <= 32'd0;
      blink         <= 1'b0;
    end else if (blink_cnt_reg == BLINK_HALF - 32'd1) begin
      blink_cnt_reg <= 32'd0;
      blink         <= ~blink;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 32'd1;
    end
  end

  // Midnight bookkeeping: hold rollovers during edits, replay one on return,
  // and merge a same-cycle midnight into that replayed pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg   <= 1'b0;
      merge_reg     <= 1'b0;
      day_increment <= 1'b0;
    end else begin
      if (rejoin) begin
        day_increment <= pending_reg | midnight;
        merge_reg     <= pending_reg | midnight;
        pending_reg   <= 1'b0;
      end else begin
        day_increment <= (state_reg == RUN) && midnight && !merge_reg;
        merge_reg     <= 1'b0;
        if (state_reg != RUN && midnight) pending_reg <= 1'b1;
      end
    end
  end

  // Registered status and load outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load       <= 1'b0;
      load_year  <= 7'd0;
      load_month <= 4'd0;
      load_day   <= 5'd0;
      set_active <= 1'b0;
      field_sel  <= 2'd0;
    end else begin
      load       <= (state_next == COMMIT);
      load_year  <= (state_next == COMMIT) ? year_reg  : 7'd0;
      load_month <= (state_next == COMMIT) ? month_reg : 4'd0;
      load_day   <= (state_next == COMMIT) ? day_reg   : 5'd0;
      set_active <= next_in_set;
      case (state_next)
        SET_YEAR:  field_sel <= 2'd1;
        SET_MONTH: field_sel <= 2'd2;
        SET_DAY:   field_sel <= 2'd3;
        default:   field_sel <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_date_set_ctrl.sv
// Bench for date_set_ctrl: directed scenarios plus randomized edit sessions
// checked against an arithmetic calendar model.
module tb_date_set_ctrl;

  logic       clk;
  logic       rst;
  logic       midnight;
  logic       btn_mode;
  logic       btn_inc;
  logic [6:0] cur_year;
  logic [3:0] cur_month;
  logic [4:0] cur_day;
  logic       day_increment;
  logic       load;
  logic [6:0] load_year;
  logic [3:0] load_month;
  logic [4:0] load_day;
  logic       set_active;
  logic [1:0] field_sel;
  logic       blink;

  int total = 0;
  int bad   = 0;

  int load_seen;
  int inc_seen;
  int ly, lm, ld;
  int fs_obs[4];

  date_set_ctrl #(
    .TIMEOUT_CYCLES(32'd16),
    .BLINK_HALF    (32'd4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .midnight     (midnight),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .cur_year     (cur_year),
    .cur_month    (cur_month),
    .cur_day      (cur_day),
    .day_increment(day_increment),
    .load         (load),
    .load_year    (load_year),
    .load_month   (load_month),
    .load_day     (load_day),
    .set_active   (set_active),
    .field_sel    (field_sel),
    .blink        (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Calendar model: days in a month for the build being simulated.
  function automatic int dim_model(input int m, input int y);
    if (m == 2) begin
`ifdef DATE_SET_LEAP_YEAR_EN
      return (y % 4 == 0) ? 29 : 28;
`else
      return 28;
`endif
    end
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (load === 1'b1) begin
      load_seen++;
      ly = int'(load_year);
      lm = int'(load_month);
      ld = int'(load_day);
    end
    if (day_increment === 1'b1) inc_seen++;
  endtask

  task automatic press_mode(input bit with_inc);
    btn_mode = 1'b1;
    btn_inc  = with_inc;
    step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    step();
    btn_inc = 1'b0;
  endtask

  task automatic gap(input int max_gap);
    repeat ($urandom_range(0, max_gap)) step();
  endtask

  // Full edit session: mode, k1 incs, mode, k2 incs, mode, k3 incs, mode, then one RUN cycle.
  task automatic drive_edit(input int y, input int m, input int d, input int k1,
                            input int k2, input int k3, input int max_gap, input bit mix);
    load_seen = 0; inc_seen = 0; ly = -1; lm = -1; ld = -1;
    cur_year  = y[6:0];
    cur_month = m[3:0];
    cur_day   = d[4:0];
    press_mode(1'b0);
    fs_obs[0] = int'(field_sel);
    repeat (k1) begin gap(max_gap); press_inc(); end
    gap(max_gap);
    press_mode(mix);
    fs_obs[1] = int'(field_sel);
    repeat (k2) begin gap(max_gap); press_inc(); end
    gap(max_gap);
    press_mode(mix);
    fs_obs[2] = int'(field_sel);
    repeat (k3) begin gap(max_gap); press_inc(); end
    gap(max_gap);
    press_mode(mix);
    fs_obs[3] = int'(field_sel);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; midnight = 0; btn_mode = 0; btn_inc = 0;
    cur_year = 7'd10; cur_month = 4'd5; cur_day = 5'd15;
    repeat (3) step();
    total++; if (day_increment !== 1'b0) begin bad++; $display("FAIL reset_day_increment got=%b want=0", day_increment); end
    total++; if (load !== 1'b0) begin bad++; $display("FAIL reset_load got=%b want=0", load); end
    total++; if ({load_year, load_month, load_day} !== 16'd0) begin bad++; $display("FAIL reset_load_vals got=%0d/%0d/%0d want=0/0/0", load_year, load_month, load_day); end
    total++; if (set_active !== 1'b0) begin bad++; $display("FAIL reset_set_active got=%b want=0", set_active); end
    total++; if (field_sel !== 2'd0) begin bad++; $display("FAIL reset_field_sel got=%0d want=0", field_sel); end
    total++; if (blink !== 1'b0) begin bad++; $display("FAIL reset_blink got=%b want=0", blink); end
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    total++; if (set_active !== 1'b0) begin bad++; $display("FAIL reset_hold_mode got=%b want=0", set_active); end
    rst = 1'b0;
    step();
    total++; if (set_active !== 1'b0) begin bad++; $display("FAIL reset_release got=%b want=0", set_active); end
    $display("test_reset complete");
  endtask

  task automatic test_midnight_run();
    for (int it = 0; it < 3; it++) begin
      load_seen = 0; inc_seen = 0;
      repeat ($urandom_range(2, 9)) step();
      total++; if (day_increment !== 1'b0) begin bad++; $display("FAIL run_pre_pulse got=%b want=0", day_increment); end
      midnight = 1'b1; step(); midnight = 1'b0;
      total++; if (day_increment !== 1'b1) begin bad++; $display("FAIL run_pulse got=%b want=1", day_increment); end
      step();
      total++; if (day_increment !== 1'b0) begin bad++; $display("FAIL run_pulse_end got=%b want=0", day_increment); end
      repeat (3) step();
      total++; if (inc_seen != 1 || load_seen != 0) begin bad++; $display("FAIL run_counts got=inc%0d,load%0d want=inc1,load0", inc_seen, load_seen); end
      $display("midnight in RUN #%0d: pulses=%0d loads=%0d", it, inc_seen, load_seen);
    end
  endtask

  task automatic check_edit(input string name, input int ey, input int em, input int ed);
    total++; if (load_seen != 1) begin bad++; $display("FAIL %s_load_count got=%0d want=1", name, load_seen); end
    total++; if (ly != ey || lm != em || ld != ed) begin bad++; $display("FAIL %s_load_vals got=%0d/%0d/%0d want=%0d/%0d/%0d", name, ly, lm, ld, ey, em, ed); end
    total++; if (fs_obs[0] != 1 || fs_obs[1] != 2 || fs_obs[2] != 3 || fs_obs[3] != 0) begin bad++; $display("FAIL %s_field_sel got=%0d,%0d,%0d,%0d want=1,2,3,0", name, fs_obs[0], fs_obs[1], fs_obs[2], fs_obs[3]); end
    total++; if (set_active !== 1'b0 || load !== 1'b0) begin bad++; $display("FAIL %s_back_to_run got=sa%b,load%b want=sa0,load0", name, set_active, load); end
    $display("edit %s: load=%0d/%0d/%0d loads=%0d", name, ly, lm, ld, load_seen);
  endtask

  task automatic test_edit_commit();
    drive_edit(24, 6, 6, 2, 1, 0, 0, 1'b0);
    check_edit("commit_basic", 26, 7, 6);
  endtask

  task automatic test_clamp();
    drive_edit(20, 3, 31, 0, 1, 0, 1, 1'b0);
    check_edit("clamp_april", 20, 4, 30);
    drive_edit(20, 3, 31, 0, 1, 1, 1, 1'b0);
    check_edit("april_wrap", 20, 4, 1);
    drive_edit(99, 12, 5, 1, 1, 0, 0, 1'b1);
    check_edit("year_month_wrap", 0, 1, 5);
  endtask

  task automatic test_feb();
    int feb24;
`ifdef DATE_SET_LEAP_YEAR_EN
    feb24 = 29;
`else
    feb24 = 28;
`endif
    drive_edit(24, 2, 31, 0, 0, 0, 0, 1'b0);
    check_edit("feb_y24", 24, 2, feb24);
    drive_edit(23, 2, 31, 0, 0, 0, 0, 1'b0);
    check_edit("feb_y23", 23, 2, 28);
  endtask

  task automatic test_midnight_pending(input bit collide);
    load_seen = 0; inc_seen = 0;
    cur_year = 7'd30; cur_month = 4'd8; cur_day = 5'd9;
    press_mode(1'b0); press_mode(1'b0);
    step();
    midnight = 1'b1; step(); midnight = 1'b0;
    total++; if (day_increment !== 1'b0) begin bad++; $display("FAIL pend_no_pulse_in_set got=%b want=0", day_increment); end
    step();
    press_mode(1'b0); press_mode(1'b0);
    total++; if (load !== 1'b1 || day_increment !== 1'b0) begin bad++; $display("FAIL pend_commit got=load%b,inc%b want=load1,inc0", load, day_increment); end
    step();
    total++; if (day_increment !== 1'b1) begin bad++; $display("FAIL pend_replay got=%b want=1", day_increment); end
    midnight = collide; step(); midnight = 1'b0;
    total++; if (day_increment !== 1'b0) begin bad++; $display("FAIL pend_single got=%b want=0", day_increment); end
    repeat (4) step();
    total++; if (inc_seen != 1 || load_seen != 1) begin bad++; $display("FAIL pend_counts got=inc%0d,load%0d want=inc1,load1", inc_seen, load_seen); end
    $display("pending midnight collide=%0d: pulses=%0d loads=%0d", collide, inc_seen, load_seen);
  endtask

  task automatic test_timeout();
    int sa_cycles;
    load_seen = 0; inc_seen = 0; sa_cycles = 0;
    press_mode(1'b0);
    for (int i = 0; i < 40; i++) begin
      if (set_active !== 1'b1) break;
      sa_cycles++;
      total++; if (blink !== 1'(((i / 4) % 2))) begin bad++; $display("FAIL timeout_blink[%0d] got=%b want=%0d", i, blink, (i / 4) % 2); end
      total++; if (day_increment !== 1'b0) begin bad++; $display("FAIL timeout_inc_in_set[%0d] got=%b want=0", i, day_increment); end
      midnight = (i == 5);
      step();
      midnight = 1'b0;
    end
    total++; if (sa_cycles != 16) begin bad++; $display("FAIL timeout_length got=%0d want=16", sa_cycles); end
    total++; if (field_sel !== 2'd0 || blink !== 1'b0) begin bad++; $display("FAIL timeout_run_outputs got=fs%0d,blink%b want=fs0,blink0", field_sel, blink); end
    total++; if (day_increment !== 1'b1) begin bad++; $display("FAIL timeout_replay got=%b want=1", day_increment); end
    step();
    total++; if (load_seen != 0 || inc_seen != 1) begin bad++; $display("FAIL timeout_counts got=load%0d,inc%0d want=load0,inc1", load_seen, inc_seen); end
    $display("timeout: set cycles=%0d loads=%0d pulses=%0d", sa_cycles, load_seen, inc_seen);
  endtask

  task automatic test_blink_restart();
    int n;
    load_seen = 0;
    press_mode(1'b0);
    repeat (5) step();
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL blink_lit got=%b want=1", blink); end
    press_inc();
    total++; if (blink !== 1'b0) begin bad++; $display("FAIL blink_inc_restart got=%b want=0", blink); end
    repeat (3) step();
    total++; if (blink !== 1'b0) begin bad++; $display("FAIL blink_dark_hold got=%b want=0", blink); end
    step();
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL blink_relit got=%b want=1", blink); end
    press_mode(1'b0);
    total++; if (blink !== 1'b0 || field_sel !== 2'd2) begin bad++; $display("FAIL blink_field_restart got=blink%b,fs%0d want=blink0,fs2", blink, field_sel); end
    n = 0;
    while (set_active === 1'b1 && n < 40) begin step(); n++; end
    total++; if (set_active !== 1'b0 || load_seen != 0) begin bad++; $display("FAIL blink_exit got=sa%b,load%0d want=sa0,load0", set_active, load_seen); end
    $display("blink restart: exit after %0d cycles", n);
  endtask

  task automatic test_reset_mid_edit();
    load_seen = 0;
    press_mode(1'b0); press_mode(1'b0); press_mode(1'b0);
    total++; if (field_sel !== 2'd3) begin bad++; $display("FAIL rstmid_in_day got=%0d want=3", field_sel); end
    #1 rst = 1'b1;
    #1;
    total++; if ({day_increment, load, load_year, load_month, load_day, set_active, field_sel, blink} !== 22'd0)
      begin bad++; $display("FAIL rstmid_async got=inc%b load%b %0d/%0d/%0d sa%b fs%0d blink%b want=all0", day_increment, load, load_year, load_month, load_day, set_active, field_sel, blink); end
    step();
    rst = 1'b0;
    repeat (3) step();
    total++; if (load_seen != 0 || set_active !== 1'b0 || field_sel !== 2'd0) begin bad++; $display("FAIL rstmid_after got=load%0d,sa%b,fs%0d want=load0,sa0,fs0", load_seen, set_active, field_sel); end
    $display("reset mid-edit: loads=%0d", load_seen);
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      int y, m, d, k1, k2, k3, ey, em, ed, dm;
      bit mix;
      y  = $urandom_range(0, 99);
      m  = $urandom_range(1, 12);
      d  = $urandom_range(1, 31);
      k1 = $urandom_range(0, 5);
      k2 = $urandom_range(0, 14);
      k3 = $urandom_range(0, 34);
      mix = 1'($urandom_range(0, 1));
      ey = (y + k1) % 100;
      em = ((m - 1 + k2) % 12) + 1;
      dm = dim_model(em, ey);
      ed = (d > dm) ? dm : d;
      ed = ((ed - 1 + k3) % dm) + 1;
      drive_edit(y, m, d, k1, k2, k3, 3, mix);
      total++; if (load_seen != 1) begin bad++; $display("FAIL rand%0d_load_count got=%0d want=1", it, load_seen); end
      total++; if (ly != ey || lm != em || ld != ed) begin bad++; $display("FAIL rand%0d_vals got=%0d/%0d/%0d want=%0d/%0d/%0d", it, ly, lm, ld, ey, em, ed); end
      total++; if (fs_obs[0] != 1 || fs_obs[1] != 2 || fs_obs[2] != 3 || fs_obs[3] != 0) begin bad++; $display("FAIL rand%0d_field_sel got=%0d,%0d,%0d,%0d want=1,2,3,0", it, fs_obs[0], fs_obs[1], fs_obs[2], fs_obs[3]); end
      $display("rand %0d: cur=%0d/%0d/%0d inc=%0d,%0d,%0d mix=%0d -> load=%0d/%0d/%0d", it, y, m, d, k1, k2, k3, mix, ly, lm, ld);
    end
  endtask

  initial begin
    test_reset();
    test_midnight_run();
    test_edit_commit();
    test_clamp();
    test_feb();
    test_midnight_pending(1'b0);
    test_midnight_pending(1'b1);
    test_timeout();
    test_blink_restart();
    test_reset_mid_edit();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
